multicycle_controller: RTL and testbench

//  Control FSM for the multicycle RV32I datapath; drives the ALU's ALUControl/SrcA/SrcB select and consumes its Zero flag.

---
 rtl/multicycle_controller_pkg.sv | 73 +++++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller_alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 155 +++++++++++++++
 tb/tb_multicycle_controller.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// The FSM states, opcode values and datapath mux codes are defined here once.
package riscv_ctrl_pkg;

  localparam int OP_W     = 7;
  localparam int ALUCTL_W = 3;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b100;

  // Coarse ALU request from the FSM; ALUOP_FUNC defers to funct3/funct7.
  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10,
    ALUOP_RSVD = 2'b11
  } alu_op_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
    logic       illegal_instr;
  } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
// master = control unit, slave = datapath side that consumes the controls.
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [OP_W-1:0]     op;
  logic [2:0]          funct3;
  logic                funct7b5;
  logic                Zero;
  logic                MemReady;

  logic                PCWrite;
  logic                AdrSrc;
  logic                MemWrite;
  logic                IRWrite;
  logic                RegWrite;
  logic [1:0]          ResultSrc;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ImmSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic                IllegalInstr;

  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
  );

  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr
  );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp plus funct fields to ALUControl.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t             alu_op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                op5,
  output logic [ALUCTL_W-1:0] alu_control
);

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          // funct7b5 only means sub for register-register ops; addi ignores it.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:   alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath (lw, sw, R, I-ALU, beq, jal).
// Moore outputs per state, plus Mealy PCWrite in FETCH (MemReady) and BEQ (Zero).
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // NOTE: only the state register is reset; every output is decoded from it,
  // so reset alone returns the whole controller to a known FETCH.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for sequential state so all flops update together.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = bus.MemReady;
        ctrl.pc_write   = bus.MemReady;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BEQ, OP_JAL: ctrl.illegal_instr = 1'b0;
          default:                                          ctrl.illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = bus.Zero;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      default: ctrl = '0;
    endcase

    // Reset suppresses every write this very cycle and parks muxes on FETCH.
    if (rst) begin
      ctrl            = '0;
      ctrl.alu_src_a  = SRCA_PC;
      ctrl.alu_src_b  = SRCB_FOUR;
      ctrl.alu_op     = ALUOP_ADD;
      ctrl.result_src = RES_ALURESULT;
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (ctrl.alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.ALUControl)
  );

  assign bus.PCWrite      = ctrl.pc_write;
  assign bus.AdrSrc       = ctrl.adr_src;
  assign bus.MemWrite     = ctrl.mem_write;
  assign bus.IRWrite      = ctrl.ir_write;
  assign bus.RegWrite     = ctrl.reg_write;
  assign bus.ResultSrc    = ctrl.result_src;
  assign bus.ALUSrcA      = ctrl.alu_src_a;
  assign bus.ALUSrcB      = ctrl.alu_src_b;
  assign bus.IllegalInstr = ctrl.illegal_instr;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares the full control word against hand-computed vectors.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Control word order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ImmSrc ALUControl IllegalInstr
  function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [1:0] imm, input logic [2:0] ctl,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ctl, ill};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
            bus.IllegalInstr};
  endfunction

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [16:0] exp);
    logic [16:0] obs;
    @(negedge clk);
    obs = observed();
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
  endtask

  initial begin
    rst          = 1'b1;
    bus.MemReady = 1'b1;
    bus.Zero     = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0);

    // reset held two cycles with MemReady=1: no enables, FETCH mux values
    cyc("rst0", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("rst1", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    rst = 1'b0;

    // lw: FETCH DECODE MEMADR MEMREAD MEMWB
    cyc("lw_fetch",   v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("lw_decode",  v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("lw_memadr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    cyc("lw_memread", v(0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    cyc("lw_memwb",   v(0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 0));

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1);
    cyc("sub_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("sub_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("sub_execr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0));
    cyc("sub_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

    // addi with funct7b5=1 still adds
    set_instr(7'b0010011, 3'b000, 1'b1);
    cyc("addi_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("addi_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("addi_execi",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0));
    cyc("addi_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

    // slti
    set_instr(7'b0010011, 3'b010, 1'b0);
    cyc("slti_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("slti_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("slti_execi",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b100, 0));
    cyc("slti_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

    // R-type and, then an unlisted funct3 (sll) falls back to add
    set_instr(7'b0110011, 3'b111, 1'b0);
    cyc("and_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("and_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("and_execr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010, 0));
    cyc("and_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    set_instr(7'b0110011, 3'b001, 1'b0);
    cyc("sll_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("sll_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0));
    cyc("sll_execr",  v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000, 0));
    cyc("sll_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0));

    // beq taken
    set_instr(7'b1100011, 3'b000, 1'b0);
    bus.Zero = 1'b1;
    cyc("beqt_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    cyc("beqt_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0));
    cyc("beqt_beq",    v(1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));
    // beq not taken, proving return to FETCH after 3 cycles
    bus.Zero = 1'b0;
    cyc("beqn_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0));
    cyc("beqn_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0));
    cyc("beqn_beq",    v(0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 0));

    // sw with three memory wait cycles
    set_instr(7'b0100011, 3'b010, 1'b0);
    cyc("sw_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    cyc("sw_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0));
    cyc("sw_memadr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    bus.MemReady = 1'b0;
    cyc("sw_wait0", v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    cyc("sw_wait1", v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    cyc("sw_wait2", v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    bus.MemReady = 1'b1;
    cyc("sw_done",  v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));

    // sw interrupted by reset mid-MEMWRITE
    cyc("swr_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    cyc("swr_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0));
    cyc("swr_memadr", v(0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0));
    bus.MemReady = 1'b0;
    cyc("swr_memwr",  v(0,1,1,0,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0));
    rst = 1'b1;
    cyc("swr_rst",    v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    rst = 1'b0;
    // back in FETCH, memory not ready: no fetch, state holds
    cyc("fetch_hold0", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    cyc("fetch_hold1", v(0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0));

    // jal: FETCH DECODE JAL ALUWB
    bus.MemReady = 1'b1;
    set_instr(7'b1101111, 3'b000, 1'b0);
    cyc("jal_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0));
    cyc("jal_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0));
    cyc("jal_jal",    v(1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0));
    cyc("jal_aluwb",  v(0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 0));

    // unsupported opcode: one-cycle IllegalInstr, then FETCH
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill_fetch",  v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));
    cyc("ill_decode", v(0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1));
    cyc("ill_next",   v(1,0,0,1,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
